pll_lock_supervisor: RTL and testbench

- Sits on the PLL reference-clock side: drives the PLL reset input and consumes the PLL lock indication.
- Sequences PLL reset pulses and qualifies lock over a stability window before releasing downstream logic.
- Detects loss of lock and retries on lock timeout, with bounded retries and a fault state.
- Runs entirely on refclk (50 MHz); the lock input is treated as asynchronous.

---
 rtl/pll_lock_supervisor_if.sv | 49 ++++
 rtl/pll_lock_supervisor.sv | 167 ++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/pll_lock_supervisor_if.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor_if
//   Groups the PLL-facing and downstream-facing signals of the lock supervisor.
//
//   locked        PLL lock flag, asynchronous to refclk
//   clear_fault   synchronous pulse that leaves the fault state
//   pll_rst       active-high reset to the PLL
//   sys_ready     lock qualified, downstream logic may leave reset
//   fault         retries exhausted
//   retry_cnt     lock timeouts since the last qualified lock
//   lock_loss_cnt saturating count of lock losses while running
//
//   slave  : the supervisor (consumes locked/clear_fault, drives the rest)
//   master : the environment around it (PLL model, system controller)
// -----------------------------------------------------------------------------
interface pll_lock_supervisor_if #(
  parameter int MAX_RETRIES = 4,
  parameter int CNT_W       = 8
);
  localparam int RTY_W = $clog2(MAX_RETRIES + 1);

  logic             locked;
  logic             clear_fault;
  logic             pll_rst;
  logic             sys_ready;
  logic             fault;
  logic [RTY_W-1:0] retry_cnt;
  logic [CNT_W-1:0] lock_loss_cnt;

  modport master (
    output locked,
    output clear_fault,
    input  pll_rst,
    input  sys_ready,
    input  fault,
    input  retry_cnt,
    input  lock_loss_cnt
  );

  modport slave (
    input  locked,
    input  clear_fault,
    output pll_rst,
    output sys_ready,
    output fault,
    output retry_cnt,
    output lock_loss_cnt
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
//   Sequences PLL reset pulses, qualifies the lock flag over a stability
//   window, retries on lock timeout with a bounded retry count, and enters a
//   sticky fault state when retries are exhausted. Runs entirely on refclk.
//
//   refclk  reference clock (sole clock)
//   rst     asynchronous active-low reset
//   pll     pll_lock_supervisor_if.slave:
//             in : locked (async), clear_fault
//             out: pll_rst, sys_ready, fault, retry_cnt, lock_loss_cnt
//
//   All outputs are registered together with the state, so none of them has
//   a combinational path from an input.
// -----------------------------------------------------------------------------
module pll_lock_supervisor #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int STABLE_CYCLES       = 1024,
  parameter int MAX_RETRIES         = 4,
  parameter int CNT_W               = 8
) (
  input  logic                 refclk,
  input  logic                 rst,
  pll_lock_supervisor_if.slave pll
);

  localparam int RTY_W      = $clog2(MAX_RETRIES + 1);
  localparam int TMR_MAX_RT = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                              RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int TMR_MAX    = (TMR_MAX_RT > STABLE_CYCLES) ? TMR_MAX_RT : STABLE_CYCLES;
  // One shared timer; it only ever needs to reach TMR_MAX-1.
  localparam int TMR_W      = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(RST_PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] STB_LAST = TMR_W'(STABLE_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRIES - 1);
  localparam logic [CNT_W-1:0] LOSS_SAT = '1;

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABLE_CHECK,
    S_RUNNING,
    S_FAULT
  } state_t;

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic             locked_p0;
  logic             locked_s;
  logic             pll_rst_q;
  logic             sys_ready_q;
  logic             fault_q;
  logic [RTY_W-1:0] retry_q;
  logic [CNT_W-1:0] loss_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == LOSS_SAT) ? v : v + 1'b1;
  endfunction

  // Stage p0/p1: two-flop synchronizer for the asynchronous lock flag
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      locked_p0 <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      locked_p0 <= pll.locked;
      locked_s  <= locked_p0;
    end
  end

  // Sequencing FSM: state and every output register update on the same edge
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      state       <= S_RESET_PLL;
      timer       <= '0;
      pll_rst_q   <= 1'b1;
      sys_ready_q <= 1'b0;
      fault_q     <= 1'b0;
      retry_q     <= '0;
      loss_q      <= '0;
    end else begin
      case (state)
        S_RESET_PLL: begin
          if (timer == RST_LAST) begin
            state     <= S_WAIT_LOCK;
            timer     <= '0;
            pll_rst_q <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        S_WAIT_LOCK: begin
          // A lock seen on the final timeout cycle still counts as a lock.
          if (locked_s) begin
            state <= S_STABLE_CHECK;
            timer <= '0;
          end else if (timer == TMO_LAST) begin
            timer     <= '0;
            pll_rst_q <= 1'b1;
            retry_q   <= retry_q + 1'b1;
            if (retry_q == RTY_LAST) begin
              state   <= S_FAULT;
              fault_q <= 1'b1;
            end else begin
              state <= S_RESET_PLL;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        S_STABLE_CHECK: begin
          if (!locked_s) begin
            state <= S_WAIT_LOCK;
            timer <= '0;
          end else if (timer == STB_LAST) begin
            state       <= S_RUNNING;
            timer       <= '0;
            sys_ready_q <= 1'b1;
            retry_q     <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        S_RUNNING: begin
          if (!locked_s) begin
            state       <= S_RESET_PLL;
            timer       <= '0;
            sys_ready_q <= 1'b0;
            pll_rst_q   <= 1'b1;
            loss_q      <= sat_inc(loss_q);
          end
        end

        S_FAULT: begin
          // pll_rst stays high across the exit so the next pulse is seamless.
          if (pll.clear_fault) begin
            state   <= S_RESET_PLL;
            timer   <= '0;
            fault_q <= 1'b0;
            retry_q <= '0;
          end
        end

        default: begin
          state       <= S_RESET_PLL;
          timer       <= '0;
          pll_rst_q   <= 1'b1;
          sys_ready_q <= 1'b0;
          fault_q     <= 1'b0;
        end
      endcase
    end
  end

  assign pll.pll_rst       = pll_rst_q;
  assign pll.sys_ready     = sys_ready_q;
  assign pll.fault         = fault_q;
  assign pll.retry_cnt     = retry_q;
  assign pll.lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_supervisor
//   Directed bench for pll_lock_supervisor with small parameters
//   (pulse 4, timeout 100, stable 16, 3 retries, 2-bit loss counter).
//   Inputs change 1 time unit after a rising edge; outputs are read there too.
// -----------------------------------------------------------------------------
module tb_pll_lock_supervisor;

  localparam int RP = 4;
  localparam int TO = 100;
  localparam int SC = 16;
  localparam int MR = 3;
  localparam int CW = 2;
  localparam int BOUND = 400;

  logic refclk = 1'b0;
  logic rst    = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pll_lock_supervisor_if #(.MAX_RETRIES(MR), .CNT_W(CW)) pif ();

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES   (RP),
    .LOCK_TIMEOUT_CYCLES(TO),
    .STABLE_CYCLES      (SC),
    .MAX_RETRIES        (MR),
    .CNT_W              (CW)
  ) dut (
    .refclk(refclk),
    .rst   (rst),
    .pll   (pif)
  );

  always #10 refclk = ~refclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, errors so far %0d", errors);
    $fatal(1);
  end

  // ---------------- stimulus helpers (no checking inside) ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic count_until_fall(output int n);
    n = 0;
    while (pif.pll_rst !== 1'b0 && n < BOUND) begin tick(1); n++; end
  endtask

  task automatic count_until_rise(output int n);
    n = 0;
    while (pif.pll_rst !== 1'b1 && n < BOUND) begin tick(1); n++; end
  endtask

  task automatic count_until_ready(output int n);
    n = 0;
    while (pif.sys_ready !== 1'b1 && n < BOUND) begin tick(1); n++; end
  endtask

  task automatic count_until_not_ready(output int n);
    n = 0;
    while (pif.sys_ready !== 1'b0 && n < BOUND) begin tick(1); n++; end
  endtask

  task automatic apply_reset();
    rst             = 1'b0;
    pif.locked      = 1'b0;
    pif.clear_fault = 1'b0;
    tick(3);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int n;
    rst             = 1'b0;
    pif.locked      = 1'b0;
    pif.clear_fault = 1'b1;   // reset must win over clear_fault
    tick(3);
    checks++; if (pif.pll_rst !== 1'b1) begin errors++; $display("FAIL reset_pll_rst: got %b expected 1", pif.pll_rst); end
    checks++; if (pif.sys_ready !== 1'b0) begin errors++; $display("FAIL reset_sys_ready: got %b expected 0", pif.sys_ready); end
    checks++; if (pif.fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", pif.fault); end
    checks++; if (int'(pif.retry_cnt) !== 0) begin errors++; $display("FAIL reset_retry_cnt: got %0d expected 0", pif.retry_cnt); end
    checks++; if (int'(pif.lock_loss_cnt) !== 0) begin errors++; $display("FAIL reset_loss_cnt: got %0d expected 0", pif.lock_loss_cnt); end
    pif.clear_fault = 1'b0;
    rst = 1'b1;
    count_until_fall(n);
    checks++; if (n !== RP) begin errors++; $display("FAIL reset_pulse_len: got %0d expected %0d", n, RP); end
  endtask

  task automatic test_lock_basic();
    int n;
    tick(10);
    pif.locked = 1'b1;
    count_until_ready(n);
    checks++; if (n !== 19) begin errors++; $display("FAIL basic_ready_latency: got %0d expected 19", n); end
    checks++; if (int'(pif.retry_cnt) !== 0) begin errors++; $display("FAIL basic_retry_cnt: got %0d expected 0", pif.retry_cnt); end
    checks++; if (pif.fault !== 1'b0) begin errors++; $display("FAIL basic_fault: got %b expected 0", pif.fault); end
    checks++; if (pif.pll_rst !== 1'b0) begin errors++; $display("FAIL basic_pll_rst: got %b expected 0", pif.pll_rst); end
  endtask

  task automatic test_lock_loss();
    int n;
    pif.locked = 1'b0;
    count_until_not_ready(n);
    checks++; if (n !== 3) begin errors++; $display("FAIL loss_drop_latency: got %0d expected 3", n); end
    checks++; if (pif.pll_rst !== 1'b1) begin errors++; $display("FAIL loss_pll_rst: got %b expected 1", pif.pll_rst); end
    checks++; if (int'(pif.lock_loss_cnt) !== 1) begin errors++; $display("FAIL loss_cnt: got %0d expected 1", pif.lock_loss_cnt); end
    count_until_fall(n);
    checks++; if (n !== RP) begin errors++; $display("FAIL loss_pulse_len: got %0d expected %0d", n, RP); end
    pif.locked = 1'b1;
    count_until_ready(n);
    checks++; if (n !== 19) begin errors++; $display("FAIL loss_relock_latency: got %0d expected 19", n); end
  endtask

  task automatic test_timeout_fault();
    int n;
    apply_reset();
    rst = 1'b1;
    count_until_fall(n);
    checks++; if (n !== RP) begin errors++; $display("FAIL tmo_first_pulse: got %0d expected %0d", n, RP); end
    for (int i = 1; i < MR; i++) begin
      count_until_rise(n);
      checks++; if (n !== TO) begin errors++; $display("FAIL tmo_low_len_%0d: got %0d expected %0d", i, n, TO); end
      checks++; if (int'(pif.retry_cnt) !== i) begin errors++; $display("FAIL tmo_retry_cnt_%0d: got %0d expected %0d", i, pif.retry_cnt, i); end
      checks++; if (pif.fault !== 1'b0) begin errors++; $display("FAIL tmo_fault_early_%0d: got %b expected 0", i, pif.fault); end
      count_until_fall(n);
      checks++; if (n !== RP) begin errors++; $display("FAIL tmo_pulse_len_%0d: got %0d expected %0d", i, n, RP); end
    end
    count_until_rise(n);
    checks++; if (n !== TO) begin errors++; $display("FAIL tmo_last_low_len: got %0d expected %0d", n, TO); end
    checks++; if (pif.fault !== 1'b1) begin errors++; $display("FAIL tmo_fault_set: got %b expected 1", pif.fault); end
    checks++; if (int'(pif.retry_cnt) !== MR) begin errors++; $display("FAIL tmo_retry_max: got %0d expected %0d", pif.retry_cnt, MR); end
    tick(30);
    checks++; if (pif.pll_rst !== 1'b1 || pif.fault !== 1'b1) begin errors++; $display("FAIL fault_hold: got pll_rst=%b fault=%b expected 1/1", pif.pll_rst, pif.fault); end
    checks++; if (int'(pif.retry_cnt) !== MR) begin errors++; $display("FAIL fault_hold_retry: got %0d expected %0d", pif.retry_cnt, MR); end
    pif.clear_fault = 1'b1;
    tick(1);
    pif.clear_fault = 1'b0;
    checks++; if (pif.fault !== 1'b0) begin errors++; $display("FAIL clear_fault: got %b expected 0", pif.fault); end
    checks++; if (int'(pif.retry_cnt) !== 0) begin errors++; $display("FAIL clear_retry: got %0d expected 0", pif.retry_cnt); end
    checks++; if (pif.pll_rst !== 1'b1) begin errors++; $display("FAIL clear_pll_rst: got %b expected 1", pif.pll_rst); end
    count_until_fall(n);
    checks++; if (n !== RP) begin errors++; $display("FAIL clear_pulse_len: got %0d expected %0d", n, RP); end
  endtask

  task automatic test_glitch();
    int n;
    logic seen;
    apply_reset();
    rst = 1'b1;
    count_until_fall(n);
    seen = 1'b0;
    tick(10);
    pif.locked = 1'b1;
    for (int i = 0; i < 10; i++) begin tick(1); seen = seen | pif.sys_ready; end
    pif.locked = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(1); seen = seen | pif.sys_ready; end
    pif.locked = 1'b1;
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL glitch_ready_early: got %b expected 0", seen); end
    count_until_ready(n);
    checks++; if (n !== 19) begin errors++; $display("FAIL glitch_ready_latency: got %0d expected 19", n); end
  endtask

  task automatic test_back_to_back();
    int n;
    int exp_loss [5];
    exp_loss = '{1, 2, 3, 3, 3};
    for (int i = 0; i < 5; i++) begin
      pif.locked = 1'b0;
      count_until_not_ready(n);
      checks++; if (n !== 3) begin errors++; $display("FAIL b2b_drop_latency_%0d: got %0d expected 3", i, n); end
      checks++; if (int'(pif.lock_loss_cnt) !== exp_loss[i]) begin errors++; $display("FAIL b2b_loss_cnt_%0d: got %0d expected %0d", i, pif.lock_loss_cnt, exp_loss[i]); end
      count_until_fall(n);
      pif.locked = 1'b1;
      count_until_ready(n);
      checks++; if (n !== 19) begin errors++; $display("FAIL b2b_relock_%0d: got %0d expected 19", i, n); end
    end
  endtask

  task automatic test_reset_midstate();
    int n;
    pif.locked = 1'b0;
    count_until_not_ready(n);
    count_until_fall(n);
    pif.locked = 1'b1;
    tick(11);    // stable counter is now 8
    checks++; if (int'(pif.lock_loss_cnt) !== 3) begin errors++; $display("FAIL mid_pre_loss_cnt: got %0d expected 3", pif.lock_loss_cnt); end
    checks++; if (pif.pll_rst !== 1'b0 || pif.sys_ready !== 1'b0) begin errors++; $display("FAIL mid_pre_state: got pll_rst=%b sys_ready=%b expected 0/0", pif.pll_rst, pif.sys_ready); end
    rst = 1'b0;
    pif.clear_fault = 1'b1;
    #1;
    checks++; if (pif.pll_rst !== 1'b1) begin errors++; $display("FAIL mid_pll_rst: got %b expected 1", pif.pll_rst); end
    checks++; if (pif.sys_ready !== 1'b0) begin errors++; $display("FAIL mid_sys_ready: got %b expected 0", pif.sys_ready); end
    checks++; if (int'(pif.lock_loss_cnt) !== 0 || int'(pif.retry_cnt) !== 0) begin errors++; $display("FAIL mid_counters: got loss=%0d retry=%0d expected 0/0", pif.lock_loss_cnt, pif.retry_cnt); end
    checks++; if (pif.fault !== 1'b0) begin errors++; $display("FAIL mid_fault: got %b expected 0", pif.fault); end
    pif.locked = 1'b0;
    tick(2);
    pif.clear_fault = 1'b0;
    rst = 1'b1;
    count_until_fall(n);
    checks++; if (n !== RP) begin errors++; $display("FAIL mid_restart_pulse: got %0d expected %0d", n, RP); end
    pif.locked = 1'b1;
    count_until_ready(n);
    checks++; if (n !== 19) begin errors++; $display("FAIL mid_restart_ready: got %0d expected 19", n); end
  endtask

  initial begin
    pif.locked      = 1'b0;
    pif.clear_fault = 1'b0;
    test_reset();
    test_lock_basic();
    test_lock_loss();
    test_timeout_fault();
    test_glitch();
    test_back_to_back();
    test_reset_midstate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
